uart_rx: RTL
============

# uart_rx

UART receiver: the receive-side counterpart of the team's `uart_tx`, sitting at the serial input pin and delivering parallel bytes to the core. It accepts 8N1 frames (configurable data width, LSB first, one stop bit) at a fixed baud rate. It synchronises the asynchronous line, validates the start bit, samples each bit at its midpoint, and presents data through a valid/ready handshake. Framing errors and overruns are flagged.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `DW`, default 8: data bits per frame.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial input, asynchronous to `clk_i`, idles high.
- `rx_data` out DW: last received byte. Reset value 0.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte. Reset value 0.
- `rx_ready` in 1: consumer accepts `rx_data` in a cycle where `rx_valid && rx_ready`.
- `rx_busy` out 1: a frame is in progress, i.e. state is not IDLE. Reset value 0.
- `frame_err` out 1: one-cycle pulse; the stop bit was sampled low. Reset value 0.
- `overrun` out 1: one-cycle pulse; a new byte overwrote an unconsumed one. Reset value 0.

## Operation
- Derived constants:
  - `BAUD_COUNT = CLK_FREQ/BAUD_RATE` (integer division).
  - `HALF = BAUD_COUNT/2`.
  - Counter width is `$clog2(BAUD_COUNT)`.
  - Bit counter width is `$clog2(DW)`, or 1 if `DW` = 1.
- `rx` passes through a 2-FF synchroniser, reset to 1, giving `rx_s`. All logic uses `rx_s` only.
- State machine, one-hot encoded. States are IDLE, START, DATA, STOP, WAIT_IDLE. Any illegal encoding goes to IDLE.
  - IDLE: when `rx_s` = 0, clear the baud counter and go to START.
  - START: count 0..HALF-1. At HALF-1, sample `rx_s`:
    - 0: clear the counter and bit counter, go to DATA.
    - 1: glitch; go to IDLE with no flags.
  - DATA: count 0..BAUD_COUNT-1. At BAUD_COUNT-1:
    - shift `rx_s` in at the MSB of the shift register (right shift, LSB first);
    - increment the bit counter;
    - after bit DW-1, go to STOP.
  - STOP: count 0..BAUD_COUNT-1. At BAUD_COUNT-1, sample `rx_s`:
    - 1: load `rx_data` from the shift register, set `rx_valid`, go to IDLE.
    - 0: pulse `frame_err`, leave `rx_data`/`rx_valid` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. A held-low line (break) therefore yields exactly one `frame_err` and no spurious frames.
- Handshake:
  - `rx_valid` stays high until accepted.
  - `rx_data` is stable while `rx_valid` = 1, except on overrun.
  - Byte completes with `rx_valid` = 1 and no accept in the same cycle: overwrite `rx_data`, keep `rx_valid` = 1, pulse `overrun`.
  - Byte completes in the same cycle as an accept: new byte loaded, `rx_valid` stays 1, no `overrun`.
- Reset mid-frame: all state, counters, flags and `rx_data` return to reset values immediately. The partial frame is discarded. After release, the receiver waits in IDLE for the next falling `rx_s`. If the line is low at release, that low is treated as a start bit.

## Timing
- Synchroniser latency is 2 cycles. IDLE to START takes 1 cycle after `rx_s` falls.
- Sample points:
  - start-bit check at HALF cycles into START;
  - each data bit and the stop bit at BAUD_COUNT cycles after the previous sample (bit midpoints).
- `rx_valid` rises at (from the `rx` falling edge) `3 + HALF + (DW+1)*BAUD_COUNT` cycles, ±1 for edge phase.
- The receiver re-enters IDLE at mid-stop-bit. It can accept a back-to-back start edge from a transmitter running up to ~half a bit faster over the frame.
- `frame_err` and `overrun` are single-cycle pulses, registered in the same cycle as the stop-bit sample.
- `rx_busy` is high from the cycle after start detection until return to IDLE.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` one-hot enum (5 states);
  - `baud_count(clk_freq, baud_rate)` function, also reused by `uart_tx`.
- Sub-module `sync_2ff`: single-bit synchroniser with parameter `RESET_VAL` (here 1). It is reusable for other async inputs.
- Everything else lives in `uart_rx`: baud counter, bit counter, shift register, handshake/flag logic and FSM.

## Test plan
All scenarios run at `CLK_FREQ`=16, `BAUD_RATE`=1 (BAUD_COUNT=16, HALF=8), `rx_ready`=1 unless stated.
- Single frame 0xA5 -> `rx_data`=0xA5 and `rx_valid` high at cycle 3+8+9*16=155 (±1); `frame_err`=`overrun`=0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two accepted bytes, in order, no flags.
- `rx` low for 3 cycles, then high -> state returns to IDLE, no `rx_valid`, no `frame_err`.
- Frame 0x3C with stop bit 0, line held low 40 cycles -> one `frame_err` pulse, `rx_valid` stays 0. Next valid frame 0x11 after the line goes high -> received correctly.
- `rx_ready`=0, frames 0x12 then 0x34 -> `overrun` pulse on the second, `rx_data`=0x34, `rx_valid`=1. Raise `rx_ready` -> `rx_valid` drops next cycle.
- Reset asserted during bit 4 of 0x5A, released, then frame 0xC3 sent -> no output for 0x5A, `rx_data`=0xC3. Plus a loopback check with `uart_tx` at default parameters, 256 random bytes, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_state_t : one-hot receiver state encoding.
//   baud_count : clock cycles per bit period. uart_tx uses it too, so both
//                ends of a link derive the bit period the same way.
package uart_pkg;

  typedef enum logic [4:0] {
    RX_IDLE      = 5'b00001,
    RX_START     = 5'b00010,
    RX_DATA      = 5'b00100,
    RX_STOP      = 5'b01000,
    RX_WAIT_IDLE = 5'b10000
  } rx_state_t;

  function automatic int unsigned baud_count(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
//   clk_i     : destination clock
//   rst_n_i   : asynchronous active-low reset; both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronised output, two cycles behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments, so meta and q both
  // update from their pre-edge values and form two real pipeline stages.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: LSB-first frames of DW data bits and one stop bit.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   rx             : serial input (asynchronous, idles high)
//   rx_data        : last received word, held while rx_valid is high
//   rx_valid       : rx_data holds an unconsumed word
//   rx_ready       : consumer takes rx_data when rx_valid && rx_ready
//   rx_busy        : a frame is in progress (state is not IDLE)
//   frame_err      : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, an unconsumed word was overwritten
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DW        = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          rx,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          overrun
);

  localparam int unsigned BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF       = BAUD_COUNT / 2;
  localparam int unsigned CW         = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam int unsigned BW         = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_COUNT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  logic          rx_s;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;

  // Control strobes from the FSM to the datapath.
  logic cnt_clr;
  logic bit_clr;
  logic shift_en;
  logic load;
  logic ferr_set;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= RX_IDLE;
    else          state <= state_n;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          cnt_clr = 1'b1;
          state_n = RX_START;
        end
      end
      RX_START: begin
        // Mid-start-bit check; a line already back high was only a glitch.
        if (cnt == HALF_LAST) begin
          if (!rx_s) begin
            cnt_clr = 1'b1;
            bit_clr = 1'b1;
            state_n = RX_DATA;
          end else begin
            state_n = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (cnt == BAUD_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        // Returning to IDLE at mid-stop-bit leaves half a bit of slack for a
        // back-to-back start edge from a slightly fast transmitter.
        if (cnt == BAUD_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            load    = 1'b1;
            state_n = RX_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        // A held-low line (break) must not look like a stream of start bits.
        if (rx_s) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // Baud counter free-runs between clears; only the compares above matter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      bit_cnt <= '0;
    else if (bit_clr)  bit_cnt <= '0;
    else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
  end

  // NOTE: the shift register is reset along with everything else so a frame
  // cut short by reset leaves nothing behind; it is a register, not a RAM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      shreg <= '0;
    else if (shift_en) shreg <= (shreg >> 1) | (DW'(rx_s) << (DW - 1));
  end

  // Handshake and flags. A word landing on an unconsumed one overwrites it
  // and pulses overrun; landing in the accept cycle is a clean hand-over.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        overrun  <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != RX_IDLE);

endmodule
